// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues word requests on a req/gnt/rvalid port and
// queues returned instructions with their PC in a first-word-fall-through FIFO.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, outstanding_q, stale_q;
  logic [63:0]     fetch_pc_q, resp_pc_q;

  logic            can_issue, grant, resp, resp_keep, pop;
  logic [CW-1:0]   outstanding_nxt, count_nxt;
  logic [CW1-1:0]  occupancy;
  logic [63:0]     redirect_base;
  entry_t          head_entry;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    occupancy       = {1'b0, count_q} + {1'b0, outstanding_q};
    can_issue       = (outstanding_q < CW'(MAX_OUT)) && (occupancy < CW1'(DEPTH));
    grant           = !rst_i && can_issue && mem_gnt_i;
    // A response with nothing outstanding belongs to no grant we know of.
    resp            = !rst_i && mem_rvalid_i && (outstanding_q != '0);
    resp_keep       = resp && (stale_q == '0);
    pop             = instr_valid_o && instr_ready_i;
    outstanding_nxt = outstanding_q + CW'(grant) - CW'(resp);
    count_nxt       = count_q + CW'(resp_keep) - CW'(pop);
    redirect_base   = redirect_pc_i & ~64'h3;
    head_entry      = fifo_q[head_q];
  end

  // Request side depends only on registered state, gated by reset.
  assign mem_req_o     = !rst_i && can_issue;
  assign mem_addr_o    = rst_i ? RESET_PC : fetch_pc_q;
  assign instr_valid_o = !rst_i && (count_q != '0);
  assign instr_o       = instr_valid_o ? head_entry.instr : 32'h0;
  assign instr_pc_o    = instr_valid_o ? head_entry.pc : 64'h0;

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      outstanding_q <= outstanding_nxt;
      if (redirect_i) begin
        // Everything still in flight (including this cycle's grant) is for the old path.
        fetch_pc_q <= redirect_base;
        resp_pc_q  <= redirect_base;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        stale_q    <= outstanding_nxt;
      end else begin
        if (grant) fetch_pc_q <= fetch_pc_q + 64'd4;
        if (resp && (stale_q != '0)) stale_q <= stale_q - CW'(1);
        if (resp_keep) begin
          tail_q    <= tail_q + PW'(1);
          resp_pc_q <= resp_pc_q + 64'd4;
        end
        if (pop) head_q <= head_q + PW'(1);
        count_q <= count_nxt;
      end
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !redirect_i && resp_keep) begin
      fifo_q[tail_q] <= '{instr: mem_rdata_i, pc: resp_pc_q};
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i |-> (outstanding_q != '0));

  a_credit: assert property (@(posedge clk_i) disable iff (rst_i)
    occupancy <= CW1'(DEPTH));

  a_stale_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    (stale_q <= outstanding_q) && (outstanding_q <= CW'(MAX_OUT)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a randomised in-order responder plus an epoch-based
// model of which words must reach decode, compared every cycle.
module tb_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [63:0] addr; int epoch; int due; } grant_t;
  typedef struct { logic [31:0] data; logic [63:0] pc; } word_t;

  int total = 0;
  int bad   = 0;

  // Responder and model state.
  grant_t      rq[$];
  word_t       exp_q[$];
  word_t       pop_log[$];
  logic [63:0] grant_log[$];
  int          epoch = 0;
  logic [63:0] ep_start = RESET_PC;
  int          n_grant = 0;
  int          n_push = 0;
  int          cyc = 0;
  int          t_first_grant = -1;
  int          t_first_valid = -1;

  // Stimulus knobs.
  logic        rst_drv = 1'b1;
  int          gnt_pct = 100, rv_pct = 100, ready_pct = 100;
  int          lat_min = 1, lat_max = 1;
  int          redir_permil = 0;
  logic        redir_force = 1'b0;
  logic [63:0] force_pc = '0;
  logic        arm_collision = 1'b0;
  logic        collision_hit = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    p = {$urandom, $urandom};
    if ($urandom_range(3) == 0) p = 64'hFFFF_FFFF_FFFF_FFF0 | (p & 64'hF);
    else if ($urandom_range(1) == 0) p = p & 64'hFFFF;
    return p;
  endfunction

  // One clock: drive after negedge, compare, then advance the model to post-edge state.
  task automatic step();
    logic   rv, g, rdy, redir, req_seen;
    grant_t r;
    @(negedge clk_i);
    rst_i = rst_drv;
    g     = ($urandom_range(99) < gnt_pct);
    rdy   = ($urandom_range(99) < ready_pct);
    rv    = !rst_drv && (rq.size() != 0) && (rq[0].due <= cyc) && ($urandom_range(99) < rv_pct);
    mem_gnt_i     = g;
    instr_ready_i = rdy;
    mem_rvalid_i  = rv;
    mem_rdata_i   = rv ? mem_word(rq[0].addr) : $urandom;
    redir = !rst_drv && (redir_force || ($urandom_range(999) < redir_permil));
    if (!rst_drv && arm_collision && rv && mem_req_o && g) begin
      redir = 1'b1;
      collision_hit = 1'b1;
      arm_collision = 1'b0;
    end
    redirect_i    = redir;
    redirect_pc_i = redir_force || collision_hit ? force_pc : rand_pc();
    #1;
    if (rst_drv) begin
      check("rst_req", mem_req_o, 0);
      check("rst_valid", instr_valid_o, 0);
      check("rst_instr", instr_o, 0);
      check("rst_pc", instr_pc_o, 0);
      check("rst_addr", mem_addr_o, RESET_PC);
    end else begin
      check("req", mem_req_o,
            (rq.size() < MAX_OUT) && (exp_q.size() + rq.size() < DEPTH));
      check("addr", mem_addr_o, ep_start + 64'(n_grant) * 64'd4);
      check("valid", instr_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("instr", instr_o, exp_q[0].data);
        check("instr_pc", instr_pc_o, exp_q[0].pc);
      end
      check("outstanding_le_max", rq.size() <= MAX_OUT, 1);
      if (instr_valid_o && t_first_valid < 0) t_first_valid = cyc;
    end
    req_seen = mem_req_o;
    // Model update for the coming posedge.
    if (rst_drv) begin
      rq.delete();
      exp_q.delete();
      epoch++;
      ep_start = RESET_PC;
      n_grant = 0;
      n_push = 0;
    end else begin
      if (req_seen && g) begin
        rq.push_back('{addr: mem_addr_o, epoch: epoch,
                       due: cyc + int'($urandom_range(lat_max, lat_min))});
        grant_log.push_back(mem_addr_o);
        if (t_first_grant < 0) t_first_grant = cyc;
        n_grant++;
      end
      if (exp_q.size() != 0 && rdy && !redir) begin
        pop_log.push_back(exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (rv) begin
        r = rq.pop_front();
        if (r.epoch == epoch && !redir) begin
          exp_q.push_back('{data: mem_word(r.addr), pc: ep_start + 64'(n_push) * 64'd4});
          n_push++;
        end
      end
      if (redir) begin
        exp_q.delete();
        epoch++;
        ep_start = redirect_pc_i & ~64'h3;
        n_grant = 0;
        n_push = 0;
      end
    end
    cyc++;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    grant_log.delete();
    t_first_grant = -1;
    t_first_valid = -1;
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b1;
    repeat (n) step();
    rst_drv = 1'b0;
    clear_logs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: streaming fetch, single-cycle responder, decode always ready.
    do_reset(2);
    gnt_pct = 100; rv_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    repeat (12) step();
    check("t1_addr0", grant_log[0], 64'h0);
    check("t1_addr1", grant_log[1], 64'h4);
    check("t1_addr2", grant_log[2], 64'h8);
    check("t1_pops", pop_log.size() >= 3, 1);
    check("t1_pc0", pop_log[0].pc, 64'h0);
    check("t1_pc1", pop_log[1].pc, 64'h4);
    check("t1_pc2", pop_log[2].pc, 64'h8);
    check("t1_data0", pop_log[0].data, mem_word(64'h0));
    check("t1_latency", t_first_valid - t_first_grant, 2);

    // 2: decode stalled -> exactly DEPTH grants, then one slot frees one request.
    do_reset(1);
    ready_pct = 0;
    repeat (12) step();
    check("t2_grants_full", grant_log.size(), DEPTH);
    @(posedge clk_i); #1;
    check("t2_req_blocked", mem_req_o, 0);
    check("t2_valid_full", instr_valid_o, 1);
    ready_pct = 100;
    step();
    ready_pct = 0;
    repeat (4) step();
    check("t2_grants_after_pop", grant_log.size(), DEPTH + 1);

    // 3: redirect with two grants outstanding; low address bits ignored.
    do_reset(1);
    ready_pct = 100; lat_min = 3; lat_max = 3;
    for (int k = 0; k < 10 && rq.size() != 2; k++) step();
    check("t3_two_outstanding", rq.size(), 2);
    clear_logs();
    redir_force = 1'b1; force_pc = 64'h102;
    step();
    redir_force = 1'b0;
    repeat (15) step();
    check("t3_pops", pop_log.size() > 0, 1);
    check("t3_first_pc", pop_log[0].pc, 64'h100);
    check("t3_first_data", pop_log[0].data, mem_word(64'h100));

    // 4: redirect coinciding with a response and a new grant.
    do_reset(1);
    lat_min = 2; lat_max = 2;
    force_pc = 64'h200; collision_hit = 1'b0; arm_collision = 1'b1;
    for (int k = 0; k < 30 && !collision_hit; k++) step();
    check("t4_collision_hit", collision_hit, 1);
    clear_logs();
    collision_hit = 1'b0; arm_collision = 1'b0;
    repeat (15) step();
    check("t4_pops", pop_log.size() > 0, 1);
    check("t4_first_pc", pop_log[0].pc, 64'h200);
    check("t4_first_data", pop_log[0].data, mem_word(64'h200));

    // 5: random stalls, latencies, back-pressure and redirects.
    do_reset(1);
    gnt_pct = 60; rv_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 5; redir_permil = 15;
    repeat (3000) step();
    redir_permil = 0;
    check("t5_progress", pop_log.size() > 200, 1);

    // 6: reset with FIFO half full and two requests outstanding.
    do_reset(1);
    gnt_pct = 100; rv_pct = 100; ready_pct = 0; lat_min = 5; lat_max = 5;
    for (int k = 0; k < 40 && !(exp_q.size() == 2 && rq.size() == 2); k++) step();
    check("t6_half_full", exp_q.size(), 2);
    check("t6_two_outstanding", rq.size(), 2);
    do_reset(1);
    ready_pct = 100; lat_min = 1; lat_max = 1;
    repeat (10) step();
    check("t6_restart_addr", grant_log[0], RESET_PC);
    check("t6_restart_pc", pop_log[0].pc, RESET_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
